// File: rtl/mpsoc_uart_bridge_pkg.sv
//==============================================================================
// Module      : mpsoc_uart_bridge_pkg
// Description : Shared definitions for the UART-to-Wishbone bridge: the bridge
//               FSM state type, 16550 register addresses, LSR bit indices and
//               the FCR/LCR/IER init values. Also provides the init-sequence
//               lookup used by the bridge INIT state.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package mpsoc_uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_POLL  = 3'd2,
        ST_TX_WR = 3'd3,
        ST_RX_RD = 3'd4
    } bridge_state_e;

    // 16550 register map (byte-wide, 3-bit address)
    localparam logic [2:0] c_ADR_RBR_THR = 3'd0;   // also DLL when DLAB=1
    localparam logic [2:0] c_ADR_IER_DLM = 3'd1;   // DLM when DLAB=1
    localparam logic [2:0] c_ADR_FCR     = 3'd2;
    localparam logic [2:0] c_ADR_LCR     = 3'd3;
    localparam logic [2:0] c_ADR_LSR     = 3'd5;

    // Line status register bits
    localparam int c_LSR_DR   = 0;
    localparam int c_LSR_THRE = 5;

    // Init values
    localparam logic [7:0] c_LCR_DLAB = 8'h80;     // divisor latch access bit
    localparam logic [7:0] c_FCR_INIT = 8'h07;     // enable + clear both FIFOs
    localparam logic [7:0] c_IER_INIT = 8'h00;     // bridge polls, no interrupts

    localparam logic [2:0] c_INIT_LAST_STEP = 3'd5;

    // Returns {address, data} for one step of the six-write init sequence.
    function automatic logic [10:0] init_access(
        input logic [2:0]  step,
        input logic [15:0] divisor,
        input logic [7:0]  lcr_fmt
    );
        logic [10:0] acc;
        case (step)
            3'd0:    acc = {c_ADR_LCR,     c_LCR_DLAB | lcr_fmt};
            3'd1:    acc = {c_ADR_RBR_THR, divisor[7:0]};
            3'd2:    acc = {c_ADR_IER_DLM, divisor[15:8]};
            3'd3:    acc = {c_ADR_LCR,     lcr_fmt};
            3'd4:    acc = {c_ADR_FCR,     c_FCR_INIT};
            default: acc = {c_ADR_IER_DLM, c_IER_INIT};
        endcase
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpsoc_uart_wb_bridge.sv
//==============================================================================
// Module      : mpsoc_uart_wb_bridge
// Description : Wishbone master that initialises a 16550-style UART and then
//               moves bytes between valid/ready streams and the UART.
//               TX bytes go through a one-entry holding register and are
//               written to THR in bursts of up to BURST per observed THRE.
//               Optional RX path enabled by macro MPSOC_UART_BRIDGE_RX_EN:
//               periodic LSR polling and RBR reads into rx_data_o.
// Ports       : wb_clk_i / wb_rst_i (async, active-low)
//               wbm_*      Wishbone master (one access at a time, sel=0001)
//               tx_*       inbound byte stream (valid/ready)
//               rx_*       outbound byte stream (valid/ready)
//               init_done_o high once the init writes have completed
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mpsoc_uart_wb_bridge
    import mpsoc_uart_bridge_pkg::*;
#(
    parameter logic [15:0] DIVISOR = 16'd27,
    parameter int          BURST   = 16,
    parameter logic [7:0]  LCR_FMT = 8'h03
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    output logic [3:0] wbm_sel_o,
    input  logic       wbm_ack_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       init_done_o
);

    localparam int              c_BW    = $clog2(BURST + 1);
    localparam logic [c_BW-1:0] c_BURST = c_BW'(BURST);

    bridge_state_e   r_state, w_state_nxt;
    logic [2:0]      r_step, w_step_nxt;
    logic            r_cyc, w_cyc_nxt;
    logic            r_we, w_we_nxt;
    logic [2:0]      r_adr, w_adr_nxt;
    logic [7:0]      r_dat, w_dat_nxt;
    logic            r_init_done, w_init_done_nxt;
    logic [c_BW-1:0] r_burst, w_burst_nxt;
    logic            r_hold_full, w_hold_full_nxt;
    logic [7:0]      r_hold_data, w_hold_data_nxt;

    logic [10:0]     w_init_acc;
    logic            w_bus_ack;
    logic            w_thr_ack;
    logic            w_tx_fire;
    logic            w_rx_eligible;
    logic            w_poll_due;

    assign w_init_acc = init_access(r_step, DIVISOR, LCR_FMT);
    assign w_bus_ack  = r_cyc & wbm_ack_i;
    assign w_thr_ack  = (r_state == ST_TX_WR) & w_bus_ack;
    assign tx_ready_o = r_init_done & ~r_hold_full;
    assign w_tx_fire  = tx_valid_i & tx_ready_o;

`ifdef MPSOC_UART_BRIDGE_RX_EN
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic [3:0] r_poll_cnt;

    // A new RBR read is only worth issuing once the previous byte is taken.
    assign w_rx_eligible = wbm_dat_i[c_LSR_DR] & ~r_rx_valid;
    assign w_poll_due    = (r_poll_cnt == 4'hF) & ~r_rx_valid;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_poll_cnt <= 4'd0;
        end else begin
            if ((r_state == ST_RX_RD) && w_bus_ack) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= wbm_dat_i;
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
            // Counts consecutive idle cycles; restarts whenever the bus is busy.
            r_poll_cnt <= (r_state == ST_IDLE) ? r_poll_cnt + 4'd1 : 4'd0;
        end
    end

    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;
`else
    logic w_unused_rx;

    assign w_unused_rx   = ^{rx_ready_i, wbm_dat_i};
    assign w_rx_eligible = 1'b0;
    assign w_poll_due    = 1'b0;
    assign rx_valid_o    = 1'b0;
    assign rx_data_o     = 8'h00;
`endif

    // Every bus state launches its access when the bus is quiet and retires it
    // on ack, so cyc/stb always drop for at least one cycle between accesses.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_init_done_nxt = r_init_done;
        w_burst_nxt     = r_burst;
        w_hold_full_nxt = r_hold_full;
        w_hold_data_nxt = r_hold_data;

        case (r_state)
            ST_INIT: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    {w_adr_nxt, w_dat_nxt} = w_init_acc;
                end else if (wbm_ack_i) begin
                    w_cyc_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    if (r_step == c_INIT_LAST_STEP) begin
                        w_step_nxt      = 3'd0;
                        w_init_done_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_step_nxt = r_step + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                // Remaining burst credit means THR space is already known.
                if (r_hold_full) begin
                    w_state_nxt = (r_burst != '0) ? ST_TX_WR : ST_POLL;
                end else if (w_poll_due) begin
                    w_state_nxt = ST_POLL;
                end
            end
            ST_POLL: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b0;
                    w_adr_nxt = c_ADR_LSR;
                    w_dat_nxt = 8'h00;
                end else if (wbm_ack_i) begin
                    w_cyc_nxt = 1'b0;
                    // RX wins; a pending TX byte simply triggers another poll.
                    if (w_rx_eligible) begin
                        w_state_nxt = ST_RX_RD;
                    end else if (wbm_dat_i[c_LSR_THRE] && r_hold_full) begin
                        w_burst_nxt = c_BURST;
                        w_state_nxt = ST_TX_WR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_TX_WR: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b1;
                    w_adr_nxt = c_ADR_RBR_THR;
                    w_dat_nxt = r_hold_data;
                end else if (wbm_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_burst_nxt = r_burst - c_BW'(1);
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RX_RD: begin
                if (!r_cyc) begin
                    w_cyc_nxt = 1'b1;
                    w_we_nxt  = 1'b0;
                    w_adr_nxt = c_ADR_RBR_THR;
                    w_dat_nxt = 8'h00;
                end else if (wbm_ack_i) begin
                    w_cyc_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cyc_nxt   = 1'b0;
                w_state_nxt = ST_INIT;
            end
        endcase

        // Capture takes precedence so a new byte survives a same-cycle THR ack.
        if (w_tx_fire) begin
            w_hold_full_nxt = 1'b1;
            w_hold_data_nxt = tx_data_i;
        end else if (w_thr_ack) begin
            w_hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state     <= ST_INIT;
            r_step      <= 3'd0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 3'd0;
            r_dat       <= 8'h00;
            r_init_done <= 1'b0;
            r_burst     <= '0;
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_init_done <= w_init_done_nxt;
            r_burst     <= w_burst_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_hold_data <= w_hold_data_nxt;
        end
    end

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = 4'b0001;
    assign init_done_o = r_init_done;

endmodule

`default_nettype wire

// File: tb/tb_mpsoc_uart_wb_bridge.sv
//==============================================================================
// Module      : tb_mpsoc_uart_wb_bridge
// Description : Directed self-checking bench for mpsoc_uart_wb_bridge with a
//               scripted Wishbone UART slave that logs every access.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mpsoc_uart_wb_bridge;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } acc_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o;
    logic [7:0] wbm_dat_i;
    logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
    logic [3:0] wbm_sel_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic       init_done_o;

    acc_t       acc_log[$];
    logic [7:0] lsr_q[$];
    logic [7:0] lsr_dflt = 8'h20;
    logic [7:0] rbr_val  = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    acc_t exp_init[6] = '{
        '{1'b1, 3'd3, 8'h83}, '{1'b1, 3'd0, 8'h1B}, '{1'b1, 3'd1, 8'h00},
        '{1'b1, 3'd3, 8'h03}, '{1'b1, 3'd2, 8'h07}, '{1'b1, 3'd1, 8'h00}
    };

    mpsoc_uart_wb_bridge #(
        .DIVISOR (16'd27),
        .BURST   (16),
        .LCR_FMT (8'h03)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_we_o    (wbm_we_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .init_done_o (init_done_o)
    );

    always #5 clk = ~clk;

    // UART slave: acks each access one cycle after it appears, logging it.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
                if (!wbm_we_o) begin
                    if (wbm_adr_o == 3'd5) begin
                        if (lsr_q.size() != 0) wbm_dat_i = lsr_q.pop_front();
                        else                   wbm_dat_i = lsr_dflt;
                    end else begin
                        wbm_dat_i = rbr_val;
                    end
                end
                acc_log.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : wbm_dat_i});
                wbm_ack_i = 1'b1;
            end else begin
                wbm_ack_i = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && acc_log.size() < n; i++) tick();
        check(tag, acc_log.size(), n);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b0;
        repeat (3) tick();
        acc_log.delete();
        lsr_q.delete();
        rst_n = 1'b1;
    endtask

    // Checks the six init writes and that init_done rises one cycle after the last ack.
    task automatic init_check(input string tag);
        for (int i = 0; i < 60 && !(acc_log.size() == 6 && wbm_ack_i); i++) tick();
        check({tag, "_count"}, acc_log.size(), 6);
        for (int i = 0; i < 6; i++) check({tag, "_wr"}, acc_log[i], exp_init[i]);
        check({tag, "_done_at_ack"}, init_done_o, 1'b0);
        tick();
        check({tag, "_done"}, init_done_o, 1'b1);
        check({tag, "_txrdy"}, tx_ready_o, 1'b1);
        acc_log.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 200 && !tx_ready_o; i++) tick();
        check("tx_ready_wait", tx_ready_o, 1'b1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_i = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        rx_ready_i = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_cyc",   wbm_cyc_o,   1'b0);
        check("rst_stb",   wbm_stb_o,   1'b0);
        check("rst_we",    wbm_we_o,    1'b0);
        check("rst_adr",   wbm_adr_o,   3'd0);
        check("rst_dat",   wbm_dat_o,   8'h00);
        check("rst_txrdy", tx_ready_o,  1'b0);
        check("rst_rxv",   rx_valid_o,  1'b0);
        check("rst_rxd",   rx_data_o,   8'h00);
        check("rst_done",  init_done_o, 1'b0);
        check("sel",       wbm_sel_o,   4'b0001);

        // Init sequence
        do_reset();
        init_check("init");

        // Single byte, LSR=0x60: one LSR read then the THR write
        lsr_q.push_back(8'h60);
        send_byte(8'h55);
        wait_log(2, 100, "tx1_count");
        check("tx1_poll",  acc_log[0], {1'b0, 3'd5, 8'h60});
        check("tx1_write", acc_log[1], {1'b1, 3'd0, 8'h55});
        repeat (2) tick();
        check("tx1_ready", tx_ready_o, 1'b1);

        // THRE clear three times, then set
        do_reset();
        init_check("init2");
        lsr_dflt = 8'h00;
        lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h00);
        lsr_q.push_back(8'h20);
        send_byte(8'hC3);
        wait_log(5, 200, "retry_count");
        for (int i = 0; i < 3; i++) check("retry_poll_busy", acc_log[i], {1'b0, 3'd5, 8'h00});
        check("retry_poll_ok", acc_log[3], {1'b0, 3'd5, 8'h20});
        check("retry_write",   acc_log[4], {1'b1, 3'd0, 8'hC3});
        repeat (10) tick();
        check("retry_no_extra", acc_log.size(), 5);

        // 20-byte stream: 16 writes per poll
        do_reset();
        init_check("init3");
        lsr_dflt = 8'h20;
        for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i));
        wait_log(22, 400, "burst_count");
        for (int i = 0; i < 22; i++) begin
            acc_t e;
            if (i == 0 || i == 17) e = {1'b0, 3'd5, 8'h20};
            else if (i < 17)       e = {1'b1, 3'd0, 8'h10 + 8'(i - 1)};
            else                   e = {1'b1, 3'd0, 8'h20 + 8'(i - 18)};
            check("burst_seq", acc_log[i], e);
        end

        // Reset during a THR write
        do_reset();
        init_check("init4");
        lsr_dflt = 8'h20;
        send_byte(8'h9E);
        for (int i = 0; i < 100 && !(wbm_stb_o && wbm_we_o && wbm_adr_o == 3'd0); i++) tick();
        check("midrst_in_wr", wbm_stb_o, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_cyc",   wbm_cyc_o,   1'b0);
        check("midrst_stb",   wbm_stb_o,   1'b0);
        check("midrst_we",    wbm_we_o,    1'b0);
        check("midrst_adr",   wbm_adr_o,   3'd0);
        check("midrst_txrdy", tx_ready_o,  1'b0);
        check("midrst_done",  init_done_o, 1'b0);
        repeat (2) tick();
        acc_log.delete();
        rst_n = 1'b1;
        init_check("reinit");
        repeat (20) tick();
        check("midrst_byte_dropped", acc_log.size(), 0);

`ifdef MPSOC_UART_BRIDGE_RX_EN
        // RX byte held until handshake
        do_reset();
        init_check("init5");
        lsr_dflt = 8'h00;
        lsr_q.push_back(8'h01);
        rbr_val  = 8'hA5;
        for (int i = 0; i < 100 && !rx_valid_o; i++) tick();
        check("rx_valid", rx_valid_o, 1'b1);
        check("rx_data",  rx_data_o,  8'hA5);
        lsr_dflt = 8'h01;
        repeat (60) tick();
        begin
            int n_rbr = 0;
            foreach (acc_log[i]) if (!acc_log[i].we && acc_log[i].adr == 3'd0) n_rbr++;
            check("rx_single_rbr", n_rbr, 1);
        end
        check("rx_held", rx_data_o, 8'hA5);
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        check("rx_released", rx_valid_o, 1'b0);

        // RX before TX on LSR=0x21
        do_reset();
        init_check("init6");
        lsr_dflt = 8'h20;
        lsr_q.push_back(8'h21);
        rbr_val  = 8'h3C;
        send_byte(8'h77);
        wait_log(4, 100, "prio_count");
        check("prio_poll1", acc_log[0], {1'b0, 3'd5, 8'h21});
        check("prio_rbr",   acc_log[1], {1'b0, 3'd0, 8'h3C});
        check("prio_poll2", acc_log[2], {1'b0, 3'd5, 8'h20});
        check("prio_thr",   acc_log[3], {1'b1, 3'd0, 8'h77});
`else
        // RX path absent: outputs stay zero whatever the slave reports
        lsr_dflt   = 8'h21;
        rx_ready_i = 1'b1;
        repeat (40) tick();
        check("norx_valid", rx_valid_o, 1'b0);
        check("norx_data",  rx_data_o,  8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
